// File: rtl/uart_rx_word_if.sv
// rtl/uart_rx_word_if.sv - word handshake bundle between uart_rx_word and its consumer
//
// Parameter: DATA_BYTES - bytes per word (data is 8*DATA_BYTES bits wide)
// Signals:
//   data  - assembled word, driven by the receiver
//   valid - data holds an unconsumed word, driven by the receiver
//   ready - consumer accepts data on the edge where valid && ready
// Modports: master = receiver side, slave = consumer side
interface uart_rx_word_if #(
    parameter int DATA_BYTES = 4
);
    logic [8*DATA_BYTES-1:0] data;
    logic                    valid;
    logic                    ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - UART receiver assembling DATA_BYTES bytes into one handshaked word
//
// Ports:
//   clk         - system clock
//   xreset      - asynchronous active-low reset
//   rs_rx       - asynchronous serial line, idles high
//   bus         - uart_rx_word_if.master: data/valid out, ready in
//   busy        - a frame or a partial word is in progress
//   frame_err   - 1-cycle pulse: stop bit sampled low
//   parity_err  - 1-cycle pulse: parity mismatch
//   timeout_err - 1-cycle pulse: partial word discarded after idle timeout
//   overrun     - 1-cycle pulse: word completed while previous one unconsumed
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 5,
    parameter int DATA_BYTES   = 4,
    parameter int PARITY       = 0,
    parameter int FIRST_LSB    = 1,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 xreset,
    input  logic                 rs_rx,
    uart_rx_word_if.master       bus,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 timeout_err,
    output logic                 overrun
);
    localparam int HALF     = CLKS_PER_BIT / 2;
    localparam int CYC_W    = $clog2(CLKS_PER_BIT);
    localparam int WORD_W   = 8 * DATA_BYTES;
    localparam int CNT_W    = $clog2(DATA_BYTES + 1);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_s;
    logic                rx_prev;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                par_bad;
    logic [CNT_W-1:0]    byte_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [WORD_W-1:0]   slots;
    logic [WORD_W-1:0]   data_q;
    logic                valid_q;

    logic                start_edge;
    logic                sample_tick;
    logic                word_done;
    logic [WORD_W-1:0]   word_next;
    int                  slot_sel;

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign busy      = (state != S_IDLE) || (byte_cnt != '0);

    // Previous sample resets low so the line must be seen high once before a start counts.
    assign start_edge  = rx_prev && !rx_s;
    assign sample_tick = (cyc_cnt == CYC_LAST);

    // A good stop sample on the last byte of a word completes the word on this edge.
    assign word_done = (state == S_STOP) && sample_tick && rx_s &&
                       !((PARITY != 0) && par_bad) && (byte_cnt == CNT_LAST);

    // Slots with the byte in flight merged in; used both to store and to publish a word.
    always_comb begin
        word_next = slots;
        slot_sel  = (FIRST_LSB != 0) ? int'(byte_cnt) : (DATA_BYTES - 1 - int'(byte_cnt));
        word_next[slot_sel*8 +: 8] = shreg;
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rs_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            slots       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;

            // A completed word is dropped if the old one is still held and not taken now.
            if (word_done) begin
                if (!valid_q || bus.ready) begin
                    data_q  <= word_next;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cyc_cnt <= '0;
                    if (start_edge) begin
                        state   <= S_START;
                        to_cnt  <= '0;
                        par_bad <= 1'b0;
                    end else if (byte_cnt != '0) begin
                        if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            byte_cnt    <= '0;
                            to_cnt      <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end

                S_START: begin
                    if (cyc_cnt == HALF_LAST) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        // Line back high at mid-start means a glitch: drop silently.
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (sample_tick) begin
                        cyc_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (sample_tick) begin
                        cyc_cnt <= '0;
                        par_bad <= (^{shreg, rx_s}) ^ ODD_PAR;
                        state   <= S_STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (sample_tick) begin
                        cyc_cnt <= '0;
                        state   <= S_IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                        end else if ((PARITY != 0) && par_bad) begin
                            parity_err <= 1'b1;
                            byte_cnt   <= '0;
                        end else begin
                            slots    <= word_next;
                            byte_cnt <= (byte_cnt == CNT_LAST) ? '0 : byte_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb/tb_uart_rx_word.sv - self-checking bench for uart_rx_word (4-byte no-parity and 2-byte even-parity MSB-first)
module tb_uart_rx_word;
    localparam int C        = 5;
    localparam int TO_LIMIT = 32 * C;

    logic clk = 1'b0;
    logic xreset;
    logic rx_a, rx_b;
    logic busy_a, fe_a, pe_a, te_a, ov_a;
    logic busy_b, fe_b, pe_b, te_b, ov_b;

    always #5 clk = ~clk;

    uart_rx_word_if #(.DATA_BYTES(4)) ifa ();
    uart_rx_word_if #(.DATA_BYTES(2)) ifb ();

    uart_rx_word #(.CLKS_PER_BIT(C), .DATA_BYTES(4), .PARITY(0), .FIRST_LSB(1), .TIMEOUT_BITS(32)) dut_a (
        .clk(clk), .xreset(xreset), .rs_rx(rx_a), .bus(ifa),
        .busy(busy_a), .frame_err(fe_a), .parity_err(pe_a), .timeout_err(te_a), .overrun(ov_a)
    );

    uart_rx_word #(.CLKS_PER_BIT(C), .DATA_BYTES(2), .PARITY(1), .FIRST_LSB(0), .TIMEOUT_BITS(32)) dut_b (
        .clk(clk), .xreset(xreset), .rs_rx(rx_b), .bus(ifb),
        .busy(busy_b), .frame_err(fe_b), .parity_err(pe_b), .timeout_err(te_b), .overrun(ov_b)
    );

    int errors = 0;
    int checks = 0;

    int fe_cnt_a = 0, pe_cnt_a = 0, to_cnt_a = 0, ov_cnt_a = 0;
    int fe_cnt_b = 0, pe_cnt_b = 0, to_cnt_b = 0, ov_cnt_b = 0;
    logic [31:0] words_a[$];
    logic [15:0] words_b[$];
    logic [9:0]  prev_p = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse bookkeeping: every pulse must be exactly one cycle wide.
    always @(negedge clk) begin
        logic [9:0] cur;
        cur = {fe_a, pe_a, te_a, ov_a, fe_b, pe_b, te_b, ov_b, 2'b00};
        if (xreset) begin
            if (fe_a) fe_cnt_a++;
            if (pe_a) pe_cnt_a++;
            if (te_a) to_cnt_a++;
            if (ov_a) ov_cnt_a++;
            if (fe_b) fe_cnt_b++;
            if (pe_b) pe_cnt_b++;
            if (te_b) to_cnt_b++;
            if (ov_b) ov_cnt_b++;
            if (ifa.valid && ifa.ready) words_a.push_back(ifa.data);
            if (ifb.valid && ifb.ready) words_b.push_back(ifb.data);
            for (int i = 2; i < 10; i++) begin
                if (cur[i]) begin
                    checks++;
                    if (prev_p[i]) begin
                        errors++;
                        $display("FAIL pulse_width bit%0d: high 2 cycles, required 1", i);
                    end
                end
            end
        end
        prev_p = cur;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else rx_b = v;
    endtask

    // which=1 targets the even-parity instance; bad_par inverts its parity bit.
    task automatic send_byte(input int which, input logic [7:0] b, input logic stop_bit, input logic bad_par);
        set_rx(which, 1'b0);
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, b[i]);
            wait_cyc(C);
        end
        if (which == 1) begin
            set_rx(which, (^b) ^ bad_par);
            wait_cyc(C);
        end
        set_rx(which, stop_bit);
        wait_cyc(C);
        set_rx(which, 1'b1);
        if (!stop_bit) wait_cyc(2 * C);
    endtask

    function automatic logic [63:0] pack(input logic [7:0] q[$], input int lsb_first);
        logic [63:0] w;
        int n;
        w = '0;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            if (lsb_first != 0) w = w | (64'(q[i]) << (8 * i));
            else w = w | (64'(q[i]) << (8 * (n - 1 - i)));
        end
        return w;
    endfunction

    typedef struct {
        logic [3:0][7:0] b;
        logic [31:0]     exp;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        logic [7:0] part[$];
        logic [63:0] expw[$];
        int fe0, pe0, to0, ov0, exp_fe, exp_pe, exp_to, n, bcnt;
        logic [7:0] b;
        logic seen;

        tbl[0].b = {8'h03, 8'h02, 8'h01, 8'h0A}; tbl[0].exp = 32'h0302010A;
        tbl[1].b = {8'h00, 8'hFF, 8'h00, 8'hFF}; tbl[1].exp = 32'h00FF00FF;
        tbl[2].b = {8'h80, 8'h00, 8'hAA, 8'h55}; tbl[2].exp = 32'h8000AA55;
        tbl[3].b = {8'h08, 8'h04, 8'h02, 8'h01}; tbl[3].exp = 32'h08040201;

        xreset = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ifa.ready = 1'b1; ifb.ready = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("rst_data", 64'(ifa.data), 64'(0));
        check("rst_valid", 64'(ifa.valid), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_errs", 64'({fe_a, pe_a, te_a, ov_a}), 64'(0));
        wait_cyc(1);
        xreset = 1'b1;
        wait_cyc(5);

        // Table-driven words with ready held high.
        fe0 = fe_cnt_a; pe0 = pe_cnt_a; to0 = to_cnt_a; ov0 = ov_cnt_a;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) send_byte(0, tbl[v].b[i], 1'b1, 1'b0);
            wait_cyc(2);
            check($sformatf("tbl%0d_count", v), 64'(words_a.size()), 64'(1));
            if (words_a.size() > 0) check($sformatf("tbl%0d_word", v), 64'(words_a.pop_front()), 64'(tbl[v].exp));
            check($sformatf("tbl%0d_busy", v), 64'(busy_a), 64'(0));
        end
        check("tbl_no_errs", 64'((fe_cnt_a - fe0) + (pe_cnt_a - pe0) + (to_cnt_a - to0) + (ov_cnt_a - ov0)), 64'(0));

        // 2-cycle glitch: START for HALF cycles, then silently back to IDLE.
        set_rx(0, 1'b0);
        wait_cyc(2);
        set_rx(0, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) bcnt++;
        end
        wait_cyc(1);
        check("glitch_busy_cycles", 64'(bcnt), 64'(C / 2));
        check("glitch_no_word", 64'(words_a.size()), 64'(0));
        check("glitch_no_err", 64'((fe_cnt_a - fe0) + (to_cnt_a - to0)), 64'(0));

        // Stop bit low on second byte.
        fe0 = fe_cnt_a;
        send_byte(0, 8'h99, 1'b1, 1'b0);
        send_byte(0, 8'h77, 1'b0, 1'b0);
        check("frame_err_pulse", 64'(fe_cnt_a - fe0), 64'(1));
        send_byte(0, 8'h11, 1'b1, 1'b0);
        send_byte(0, 8'h22, 1'b1, 1'b0);
        send_byte(0, 8'h33, 1'b1, 1'b0);
        send_byte(0, 8'h44, 1'b1, 1'b0);
        wait_cyc(2);
        check("after_fe_count", 64'(words_a.size()), 64'(1));
        if (words_a.size() > 0) check("after_fe_word", 64'(words_a.pop_front()), 64'(32'h44332211));

        // Timeout after a partial word.
        to0 = to_cnt_a;
        send_byte(0, 8'hE1, 1'b1, 1'b0);
        send_byte(0, 8'hE2, 1'b1, 1'b0);
        check("partial_busy", 64'(busy_a), 64'(1));
        n = 0;
        seen = 1'b0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            n++;
            if (te_a) seen = 1'b1;
        end
        check("timeout_seen", 64'(seen), 64'(1));
        check("timeout_latency", 64'(n >= TO_LIMIT - 10 && n <= TO_LIMIT + 10), 64'(1));
        wait_cyc(1);
        check("timeout_busy", 64'(busy_a), 64'(0));
        send_byte(0, 8'hA1, 1'b1, 1'b0);
        send_byte(0, 8'hB2, 1'b1, 1'b0);
        send_byte(0, 8'hC3, 1'b1, 1'b0);
        send_byte(0, 8'hD4, 1'b1, 1'b0);
        wait_cyc(2);
        check("after_to_count", 64'(words_a.size()), 64'(1));
        if (words_a.size() > 0) check("after_to_word", 64'(words_a.pop_front()), 64'(32'hD4C3B2A1));

        // Overrun while ready is low.
        ov0 = ov_cnt_a;
        ifa.ready = 1'b0;
        send_byte(0, 8'hC1, 1'b1, 1'b0); send_byte(0, 8'hD2, 1'b1, 1'b0);
        send_byte(0, 8'hE3, 1'b1, 1'b0); send_byte(0, 8'hF4, 1'b1, 1'b0);
        wait_cyc(2);
        check("hold_valid", 64'(ifa.valid), 64'(1));
        check("hold_data", 64'(ifa.data), 64'(32'hF4E3D2C1));
        send_byte(0, 8'h01, 1'b1, 1'b0); send_byte(0, 8'h02, 1'b1, 1'b0);
        send_byte(0, 8'h03, 1'b1, 1'b0); send_byte(0, 8'h04, 1'b1, 1'b0);
        wait_cyc(2);
        check("overrun_pulse", 64'(ov_cnt_a - ov0), 64'(1));
        check("overrun_keep_data", 64'(ifa.data), 64'(32'hF4E3D2C1));
        check("overrun_keep_valid", 64'(ifa.valid), 64'(1));
        ifa.ready = 1'b1;
        wait_cyc(1);
        @(negedge clk);
        check("accept_clears_valid", 64'(ifa.valid), 64'(0));
        check("accept_count", 64'(words_a.size()), 64'(1));
        if (words_a.size() > 0) check("accept_word", 64'(words_a.pop_front()), 64'(32'hF4E3D2C1));
        wait_cyc(2);

        // Randomized traffic against a byte/word-level model.
        fe0 = fe_cnt_a; to0 = to_cnt_a; ov0 = ov_cnt_a;
        exp_fe = 0; exp_to = 0;
        part.delete(); expw.delete(); words_a.delete();
        for (int e = 0; e < 100; e++) begin
            n = $urandom_range(0, 99);
            b = 8'($urandom);
            if (n < 8) begin
                send_byte(0, b, 1'b0, 1'b0);
                exp_fe++;
                part.delete();
            end else if (n < 12) begin
                wait_cyc(TO_LIMIT + 20);
                if (part.size() > 0) exp_to++;
                part.delete();
            end else begin
                send_byte(0, b, 1'b1, 1'b0);
                part.push_back(b);
                if (part.size() == 4) begin
                    expw.push_back(pack(part, 1));
                    part.delete();
                end
            end
            if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 2 * C));
        end
        wait_cyc(TO_LIMIT + 20);
        if (part.size() > 0) exp_to++;
        check("rand_a_fe", 64'(fe_cnt_a - fe0), 64'(exp_fe));
        check("rand_a_to", 64'(to_cnt_a - to0), 64'(exp_to));
        check("rand_a_ov", 64'(ov_cnt_a - ov0), 64'(0));
        check("rand_a_nwords", 64'(words_a.size()), 64'(expw.size()));
        while (words_a.size() > 0 && expw.size() > 0)
            check("rand_a_word", 64'(words_a.pop_front()), expw.pop_front());

        // Even parity, 2-byte MSB-first instance.
        pe0 = pe_cnt_b;
        send_byte(1, 8'h0A, 1'b1, 1'b1);
        wait_cyc(2);
        check("parity_err_pulse", 64'(pe_cnt_b - pe0), 64'(1));
        check("parity_err_busy", 64'(busy_b), 64'(0));
        send_byte(1, 8'h0A, 1'b1, 1'b0);
        send_byte(1, 8'h5C, 1'b1, 1'b0);
        wait_cyc(2);
        check("parity_ok_count", 64'(words_b.size()), 64'(1));
        if (words_b.size() > 0) check("parity_ok_word", 64'(words_b.pop_front()), 64'(16'h0A5C));

        fe0 = fe_cnt_b; pe0 = pe_cnt_b;
        exp_fe = 0; exp_pe = 0;
        part.delete(); expw.delete(); words_b.delete();
        for (int e = 0; e < 40; e++) begin
            n = $urandom_range(0, 99);
            b = 8'($urandom);
            if (n < 10) begin
                send_byte(1, b, 1'b1, 1'b1);
                exp_pe++;
                part.delete();
            end else if (n < 16) begin
                send_byte(1, b, 1'b0, 1'b0);
                exp_fe++;
                part.delete();
            end else begin
                send_byte(1, b, 1'b1, 1'b0);
                part.push_back(b);
                if (part.size() == 2) begin
                    expw.push_back(pack(part, 0));
                    part.delete();
                end
            end
        end
        if (part.size() > 0) begin
            send_byte(1, 8'h00, 1'b1, 1'b0);
            part.push_back(8'h00);
            expw.push_back(pack(part, 0));
            part.delete();
        end
        wait_cyc(2);
        check("rand_b_fe", 64'(fe_cnt_b - fe0), 64'(exp_fe));
        check("rand_b_pe", 64'(pe_cnt_b - pe0), 64'(exp_pe));
        check("rand_b_nwords", 64'(words_b.size()), 64'(expw.size()));
        while (words_b.size() > 0 && expw.size() > 0)
            check("rand_b_word", 64'(words_b.pop_front()), expw.pop_front());

        // Asynchronous reset in the middle of a frame.
        ifa.ready = 1'b0;
        send_byte(0, 8'h5A, 1'b1, 1'b0); send_byte(0, 8'h6B, 1'b1, 1'b0);
        send_byte(0, 8'h7C, 1'b1, 1'b0); send_byte(0, 8'h8D, 1'b1, 1'b0);
        send_byte(0, 8'h9E, 1'b1, 1'b0);
        set_rx(0, 1'b0);
        wait_cyc(20);
        check("pre_rst_valid", 64'(ifa.valid), 64'(1));
        check("pre_rst_busy", 64'(busy_a), 64'(1));
        #2 xreset = 1'b0;
        #1;
        check("async_rst_data", 64'(ifa.data), 64'(0));
        check("async_rst_valid", 64'(ifa.valid), 64'(0));
        check("async_rst_busy", 64'(busy_a), 64'(0));
        set_rx(0, 1'b1);
        wait_cyc(3);
        xreset = 1'b1;
        ifa.ready = 1'b1;
        wait_cyc(3);
        words_a.delete();
        send_byte(0, 8'h10, 1'b1, 1'b0); send_byte(0, 8'h20, 1'b1, 1'b0);
        send_byte(0, 8'h30, 1'b1, 1'b0);
        wait_cyc(2);
        check("post_rst_partial", 64'(words_a.size()), 64'(0));
        send_byte(0, 8'h40, 1'b1, 1'b0);
        wait_cyc(2);
        check("post_rst_count", 64'(words_a.size()), 64'(1));
        if (words_a.size() > 0) check("post_rst_word", 64'(words_a.pop_front()), 64'(32'h40302010));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
